dp_controller: RTL and testbench

//  Instruction-sequencing FSM for the register-file/shifter/ALU datapath. Latches one 16-bit

---
 rtl/dp_controller.sv | 171 +++++++++++++++++
 tb/tb_dp_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dp_controller.sv
// Instruction-sequencing FSM for the register-file/shifter/ALU datapath.
// Optional illegal-instruction trap state: define DP_CTRL_ILLEGAL_TRAP_EN.
`timescale 1ns/1ps

module dp_controller #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s,
  input  logic [15:0]       in,
  output logic              w,
  output logic              err,
  output logic [REG_AW-1:0] readnum,
  output logic [REG_AW-1:0] writenum,
  output logic              write,
  output logic [1:0]        vsel,
  output logic              loada,
  output logic              loadb,
  output logic              asel,
  output logic              bsel,
  output logic              loadc,
  output logic              loads,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WIMM,
    S_GETA,
    S_GETB,
    S_EXEC,
    S_WREG
`ifdef DP_CTRL_ILLEGAL_TRAP_EN
    ,
    S_ERR
`endif
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;

  // Decoded instruction fields and classes
  logic [2:0] opc;
  logic [1:0] op;
  logic       is_mov_imm;
  logic       is_mov_reg;
  logic       is_alu;
  logic       is_cmp;

  assign opc        = ir[15:13];
  assign op         = ir[12:11];
  assign is_mov_imm = (opc == OPC_MOV) && (op == OP_MOV_IMM);
  assign is_mov_reg = (opc == OPC_MOV) && (op == OP_MOV_REG);
  assign is_alu     = (opc == OPC_ALU);
  assign is_cmp     = is_alu && (op == OP_CMP);

  // Datapath fields held stable from IR for the whole operation
  assign shift  = ir[4:3];
  assign ALUop  = is_mov_reg ? 2'b00 : op;
  assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
  assign bsel   = 1'b0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset branch covers every register here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_WAIT && s) ir <= in;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    w         = 1'b0;
    err       = 1'b0;
    readnum   = '0;
    writenum  = '0;
    write     = 1'b0;
    vsel      = 2'b00;
    loada     = 1'b0;
    loadb     = 1'b0;
    asel      = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;

    unique case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_nxt = S_DECODE;
      end

      S_DECODE: begin
        if (is_mov_imm)      state_nxt = S_WIMM;
        else if (is_mov_reg) state_nxt = S_GETB;
        else if (is_alu)     state_nxt = S_GETA;
        else begin
`ifdef DP_CTRL_ILLEGAL_TRAP_EN
          state_nxt = S_ERR;
`else
          state_nxt = S_WAIT;
`endif
        end
      end

      S_WIMM: begin
        write     = 1'b1;
        writenum  = REG_AW'(ir[10:8]);
        vsel      = 2'b10;
        state_nxt = S_WAIT;
      end

      S_GETA: begin
        readnum   = REG_AW'(ir[10:8]);
        loada     = 1'b1;
        state_nxt = S_GETB;
      end

      S_GETB: begin
        readnum   = REG_AW'(ir[2:0]);
        loadb     = 1'b1;
        state_nxt = S_EXEC;
      end

      // Register MOV passes B through an ALU add with A forced to zero
      S_EXEC: begin
        asel = is_mov_reg;
        if (is_cmp) begin
          loads     = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          loadc     = 1'b1;
          state_nxt = S_WREG;
        end
      end

      S_WREG: begin
        write     = 1'b1;
        writenum  = REG_AW'(ir[7:5]);
        state_nxt = S_WAIT;
      end

`ifdef DP_CTRL_ILLEGAL_TRAP_EN
      S_ERR: begin
        err = 1'b1;
      end
`endif

      default: state_nxt = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_dp_controller.sv
// Directed self-checking bench for dp_controller: reset, each instruction
// class, back-to-back accept with s held high, mid-op reset and illegal op.
`timescale 1ns/1ps

module tb_dp_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s;
  logic [15:0] in;
  logic        w, err, write, loada, loadb, asel, bsel, loadc, loads;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;

  int n_tests = 0;
  int n_fail  = 0;

  dp_controller #(.DATA_W(16), .REG_AW(3)) dut (
    .clk(clk), .reset_n(reset_n), .s(s), .in(in),
    .w(w), .err(err), .readnum(readnum), .writenum(writenum),
    .write(write), .vsel(vsel), .loada(loada), .loadb(loadb),
    .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads),
    .shift(shift), .ALUop(ALUop), .sximm8(sximm8), .sximm5(sximm5)
  );

  always #5 clk = ~clk;

  // {loada, loadb, loadc, loads, write}
  logic [4:0] en;
  assign en = {loada, loadb, loadc, loads, write};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one instruction then count edges until w returns, bounded.
  task automatic run_to_wait(input string tag, input logic [15:0] instr, input int exp_edges);
    int edges;
    in = instr;
    s  = 1'b1;
    tick();
    s  = 1'b0;
    edges = 0;
    while (w !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    check(tag, edges, exp_edges);
  endtask

  initial begin
    reset_n = 1'b0;
    s       = 1'b0;
    in      = 16'h0000;
    #1;
    check("rst_w", w, 1);
    check("rst_en", en, 5'b00000);
    check("rst_err", err, 0);
    check("rst_sximm8", sximm8, 16'h0000);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("idle_w", w, 1);

    // MOV R0,#-5; in changes after accept and must be ignored
    in = 16'hD0FB;
    s  = 1'b1;
    tick();
    s  = 1'b0;
    in = 16'h0000;
    check("movi_dec_w", w, 0);
    check("movi_dec_en", en, 5'b00000);
    tick();
    check("movi_wimm_en", en, 5'b00001);
    check("movi_writenum", writenum, 0);
    check("movi_vsel", vsel, 2'b10);
    check("movi_sximm8", sximm8, 16'hFFFB);
    check("movi_sximm5", sximm5, 16'hFFFB);
    tick();
    check("movi_done_w", w, 1);
    check("movi_done_en", en, 5'b00000);

    // s held high: new op accepted on the first WAIT edge
    in = 16'hD0FB;
    s  = 1'b1;
    tick();
    check("hold_dec_w", w, 0);
    tick();
    tick();
    check("hold_wait_w", w, 1);
    tick();
    check("hold_reaccept_w", w, 0);
    s = 1'b0;
    tick();
    check("hold_wimm_en", en, 5'b00001);
    tick();
    check("hold_end_w", w, 1);

    // ADD R2,R1,R0,LSL
    in = 16'hA148;
    s  = 1'b1;
    tick();
    s  = 1'b0;
    check("add_dec_en", en, 5'b00000);
    tick();
    check("add_geta_en", en, 5'b10000);
    check("add_geta_rn", readnum, 1);
    tick();
    check("add_getb_en", en, 5'b01000);
    check("add_getb_rn", readnum, 0);
    check("add_shift", shift, 2'b01);
    tick();
    check("add_exec_en", en, 5'b00100);
    check("add_aluop", ALUop, 2'b00);
    check("add_asel", asel, 0);
    check("add_bsel", bsel, 0);
    tick();
    check("add_wreg_en", en, 5'b00001);
    check("add_writenum", writenum, 2);
    check("add_vsel", vsel, 2'b00);
    check("add_wreg_w", w, 0);
    tick();
    check("add_done_w", w, 1);

    // CMP R1,R2
    in = 16'hA902;
    s  = 1'b1;
    tick();
    s  = 1'b0;
    tick();
    check("cmp_geta_en", en, 5'b10000);
    check("cmp_geta_rn", readnum, 1);
    tick();
    check("cmp_getb_rn", readnum, 2);
    tick();
    check("cmp_exec_en", en, 5'b00010);
    check("cmp_aluop", ALUop, 2'b01);
    check("cmp_exec_w", w, 0);
    tick();
    check("cmp_done_w", w, 1);
    check("cmp_done_en", en, 5'b00000);

    // MOV R3,R4,LSR
    in = 16'hC074;
    s  = 1'b1;
    tick();
    s  = 1'b0;
    tick();
    check("movr_getb_en", en, 5'b01000);
    check("movr_getb_rn", readnum, 4);
    tick();
    check("movr_exec_en", en, 5'b00100);
    check("movr_asel", asel, 1);
    check("movr_aluop", ALUop, 2'b00);
    check("movr_shift", shift, 2'b10);
    tick();
    check("movr_wreg_en", en, 5'b00001);
    check("movr_writenum", writenum, 3);
    tick();
    check("movr_done_w", w, 1);

    // Latency per class
    run_to_wait("lat_movi", 16'hD0FB, 2);
    run_to_wait("lat_movr", 16'hC074, 4);
    run_to_wait("lat_cmp",  16'hA902, 4);
    run_to_wait("lat_add",  16'hA148, 5);
    run_to_wait("lat_mvn",  16'hB948, 5);

    // Reset in GETB of an ADD aborts with no later write
    in = 16'hA148;
    s  = 1'b1;
    tick();
    s  = 1'b0;
    tick();
    tick();
    check("abort_getb_en", en, 5'b01000);
    reset_n = 1'b0;
    #1;
    check("abort_w", w, 1);
    check("abort_en", en, 5'b00000);
    check("abort_ir", sximm8, 16'h0000);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_idle_en", en, 5'b00000);
      check("abort_idle_w", w, 1);
    end

    // Illegal encoding
    in = 16'hE000;
    s  = 1'b1;
    tick();
    s  = 1'b0;
    check("ill_dec_en", en, 5'b00000);
    tick();
`ifdef DP_CTRL_ILLEGAL_TRAP_EN
    check("ill_err", err, 1);
    check("ill_w", w, 0);
    s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ill_stuck_err", err, 1);
      check("ill_stuck_w", w, 0);
    end
    s = 1'b0;
    reset_n = 1'b0;
    #1;
    check("ill_rst_err", err, 0);
    check("ill_rst_w", w, 1);
    tick();
    reset_n = 1'b1;
`else
    check("ill_nop_w", w, 1);
    check("ill_nop_err", err, 0);
    check("ill_nop_en", en, 5'b00000);
`endif
    tick();
    check("final_w", w, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
